// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine: turns one load/store into one or two
// word-aligned req/ready bus transactions with lane steering and load extension.
module mem_access_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] mem_data_mem_addr,
   input  logic [2:0]            mem_data_mem_data_width,
   input  logic                  mem_data_mem_we,
   input  logic                  mem_data_mem_re,
   input  logic [DATA_WIDTH-1:0] mem_data_mem_in,
   input  logic                  pipe_adv,
   output logic                  mem_busy,
   output logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  mem_rdata_valid,
   output logic                  mem_access_fault,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [3:0]            dmem_wstrb,
   output logic [DATA_WIDTH-1:0] dmem_wdata,
   input  logic                  dmem_ready,
   input  logic [DATA_WIDTH-1:0] dmem_rdata
);

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [2:0]            code_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  we_q;
   logic [DATA_WIDTH-1:0] rdata0_q;

   logic [ADDR_WIDTH-1:0] cur_addr, base0, base1;
   logic [2:0]            cur_code;
   logic [DATA_WIDTH-1:0] cur_data;
   logic [1:0]            off;
   logic [2:0]            hi_shift;
   logic [3:0]            size_mask, strb0, strb1;
   logic                  code_legal, split, req_ok, req_fault;
   logic [DATA_WIDTH-1:0] wdata0, wdata1, raw, load_ext;

   // In IDLE the live request drives the lane logic; afterwards the captured copy does.
   always_comb begin
      cur_addr   = (state == IDLE) ? mem_data_mem_addr       : addr_q;
      cur_code   = (state == IDLE) ? mem_data_mem_data_width : code_q;
      cur_data   = (state == IDLE) ? mem_data_mem_in         : data_q;
      off        = cur_addr[1:0];
      hi_shift   = 3'd4 - {1'b0, off};
      code_legal = 1'b1;
      // NOTE: every signal in this block gets a value on every path, so no latch is inferred.
      case (cur_code)
         3'b000, 3'b100: size_mask = 4'b0001;
         3'b001, 3'b101: size_mask = 4'b0011;
         3'b010:         size_mask = 4'b1111;
         default: begin
            size_mask  = 4'b0000;
            code_legal = 1'b0;
         end
      endcase
      split  = (size_mask == 4'b0011 && off == 2'd3) || (size_mask == 4'b1111 && off != 2'd0);
      base0  = {cur_addr[ADDR_WIDTH-1:2], 2'b00};
      base1  = base0 + ADDR_WIDTH'(4);
      strb0  = size_mask << off;
      strb1  = size_mask >> hi_shift;
      wdata0 = cur_data << {off, 3'b000};
      wdata1 = cur_data >> {hi_shift, 3'b000};

      req_ok    = (mem_data_mem_we ^ mem_data_mem_re) && code_legal;
      req_fault = (mem_data_mem_we && mem_data_mem_re) ||
                  ((mem_data_mem_we || mem_data_mem_re) && !code_legal);

      raw = (state == BEAT1) ? ((rdata0_q >> {off, 3'b000}) | (dmem_rdata << {hi_shift, 3'b000}))
                             : (dmem_rdata >> {off, 3'b000});
      case (code_q)
         3'b000:  load_ext = {{24{raw[7]}}, raw[7:0]};
         3'b001:  load_ext = {{16{raw[15]}}, raw[15:0]};
         3'b100:  load_ext = {24'h0, raw[7:0]};
         3'b101:  load_ext = {16'h0, raw[15:0]};
         default: load_ext = raw;
      endcase

      mem_busy = (state == IDLE && req_ok) || state == BEAT0 || state == BEAT1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         addr_q           <= '0;
         code_q           <= '0;
         data_q           <= '0;
         we_q             <= 1'b0;
         rdata0_q         <= '0;
         mem_rdata        <= '0;
         mem_rdata_valid  <= 1'b0;
         mem_access_fault <= 1'b0;
         dmem_req         <= 1'b0;
         dmem_we          <= 1'b0;
         dmem_addr        <= '0;
         dmem_wstrb       <= '0;
         dmem_wdata       <= '0;
      end else begin
         // NOTE: all state here uses non-blocking assignment so every register sees pre-edge values.
         case (state)
            IDLE: begin
               if (req_fault) begin
                  mem_access_fault <= 1'b1;
                  mem_rdata_valid  <= 1'b0;
                  state            <= DONE;
               end else if (req_ok) begin
                  addr_q     <= mem_data_mem_addr;
                  code_q     <= mem_data_mem_data_width;
                  data_q     <= mem_data_mem_in;
                  we_q       <= mem_data_mem_we;
                  dmem_req   <= 1'b1;
                  dmem_we    <= mem_data_mem_we;
                  dmem_addr  <= base0;
                  dmem_wstrb <= mem_data_mem_we ? strb0 : 4'b0000;
                  dmem_wdata <= mem_data_mem_we ? wdata0 : '0;
                  state      <= BEAT0;
               end
            end
            BEAT0, BEAT1: begin
               if (dmem_ready) begin
                  if (state == BEAT0 && split) begin
                     rdata0_q   <= dmem_rdata;
                     dmem_addr  <= base1;
                     dmem_wstrb <= we_q ? strb1 : 4'b0000;
                     dmem_wdata <= we_q ? wdata1 : '0;
                     state      <= BEAT1;
                  end else begin
                     dmem_req        <= 1'b0;
                     dmem_we         <= 1'b0;
                     dmem_wstrb      <= 4'b0000;
                     mem_rdata_valid <= !we_q;
                     if (!we_q) mem_rdata <= load_ext;
                     state           <= DONE;
                  end
               end
            end
            DONE: begin
               mem_access_fault <= 1'b0;
               if (pipe_adv) begin
                  mem_rdata_valid <= 1'b0;
                  state           <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
